// File: rtl/bus_master_arbiter.sv
// 68000-style bus mastership arbiter: nBR/nBG/nBGACK handshake gated by the 7 MHz falling strobe.
// Optional build macro PI_MIN_OWN_EN: guarantees the Pi MIN_OWN_CLKS 7 MHz clocks between grants.
module bus_master_arbiter #(
    parameter int SYNC_STAGES  = 2,
    parameter int BG_TIMEOUT   = 4095,
    parameter int SETTLE_CLKS  = 2,
    parameter int MIN_OWN_CLKS = 8
) (
    input  logic SYSCLK,
    input  logic RESET,
    input  logic MC_CLK_FALLING,
    input  logic nBR_IN,
    input  logic nBGACK_IN,
    input  logic nAS_IN,
    input  logic ENGINE_BUSY,
    input  logic DENY_GRANT,
    output logic ENGINE_HOLD,
    output logic BG_DRIVE,
    output logic EXT_MASTER,
    output logic GRANT_TIMEOUT,
    input  logic CLR_TIMEOUT
);

    localparam int TW = $clog2(BG_TIMEOUT + 1);
    localparam int SW = $clog2(SETTLE_CLKS + 1);
    localparam logic [TW-1:0] TMO_MAX     = TW'(BG_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST    = TW'(BG_TIMEOUT - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CLKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_GRANT,
        ST_WAIT_BGACK,
        ST_OWNED,
        ST_RELEASE
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] br_sync;
    logic [SYNC_STAGES-1:0] bgack_sync;
    logic [SYNC_STAGES-1:0] as_sync;
    logic br;
    logic bgack;
    logic as;

    logic [TW-1:0] bg_cnt;
    logic [SW-1:0] settle_cnt;
    logic          own_free;
    logic          chain_ok;

    // Raw pins idle high, so the synchronisers reset to the inactive level.
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            br_sync    <= '1;
            bgack_sync <= '1;
            as_sync    <= '1;
        end else begin
            br_sync    <= {br_sync[SYNC_STAGES-2:0], nBR_IN};
            bgack_sync <= {bgack_sync[SYNC_STAGES-2:0], nBGACK_IN};
            as_sync    <= {as_sync[SYNC_STAGES-2:0], nAS_IN};
        end
    end

    assign br    = ~br_sync[SYNC_STAGES-1];
    assign bgack = ~bgack_sync[SYNC_STAGES-1];
    assign as    = ~as_sync[SYNC_STAGES-1];

`ifdef PI_MIN_OWN_EN
    localparam int MW = $clog2(MIN_OWN_CLKS + 1);
    logic [MW-1:0] min_own_cnt;

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            min_own_cnt <= '0;
        end else if (state == ST_RELEASE && MC_CLK_FALLING && settle_cnt == SETTLE_LAST) begin
            min_own_cnt <= MW'(MIN_OWN_CLKS);
        end else if (MC_CLK_FALLING && min_own_cnt != '0) begin
            min_own_cnt <= min_own_cnt - 1'b1;
        end
    end

    assign own_free = (min_own_cnt == '0);
    assign chain_ok = 1'b0;
`else
    // Without the ownership guard, MIN_OWN_CLKS has no effect.
    assign own_free = (MIN_OWN_CLKS >= 0);
    assign chain_ok = br && !DENY_GRANT;
`endif

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            ENGINE_HOLD   <= 1'b0;
            BG_DRIVE      <= 1'b0;
            EXT_MASTER    <= 1'b0;
            GRANT_TIMEOUT <= 1'b0;
            bg_cnt        <= '0;
            settle_cnt    <= '0;
        end else begin
            // NOTE: the later non-blocking assignment in this block wins, so a
            // timeout raised below overrides a clear in the same cycle.
            if (CLR_TIMEOUT) GRANT_TIMEOUT <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (br && !DENY_GRANT && own_free) begin
                        ENGINE_HOLD <= 1'b1;
                        state       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!br) begin
                        ENGINE_HOLD <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (!ENGINE_BUSY && !as) begin
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (MC_CLK_FALLING) begin
                        BG_DRIVE <= 1'b1;
                        bg_cnt   <= '0;
                        state    <= ST_WAIT_BGACK;
                    end
                end
                ST_WAIT_BGACK: begin
                    if (bg_cnt != TMO_MAX) bg_cnt <= bg_cnt + 1'b1;
                    if (bgack && !as) begin
                        BG_DRIVE   <= 1'b0;
                        EXT_MASTER <= 1'b1;
                        state      <= ST_OWNED;
                    end else if (!br && !bgack) begin
                        BG_DRIVE   <= 1'b0;
                        settle_cnt <= '0;
                        state      <= ST_RELEASE;
                    end else if (bg_cnt == TMO_LAST) begin
                        BG_DRIVE      <= 1'b0;
                        GRANT_TIMEOUT <= 1'b1;
                        settle_cnt    <= '0;
                        state         <= ST_RELEASE;
                    end
                end
                ST_OWNED: begin
                    if (!bgack) begin
                        EXT_MASTER <= 1'b0;
                        settle_cnt <= '0;
                        state      <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (MC_CLK_FALLING) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            if (chain_ok) begin
                                state <= ST_GRANT;
                            end else begin
                                ENGINE_HOLD <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    ENGINE_HOLD <= 1'b0;
                    BG_DRIVE    <= 1'b0;
                    EXT_MASTER  <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Controls 68000-style bus mastership on behalf of the Pi-side CPU emulation.
- Detects external bus requests (nBR), holds the bus transfer engine off at a cycle boundary, then issues the grant (nBG) in step with the 7 MHz falling-edge strobe.
- Tracks nBGACK ownership and returns the bus to the transfer engine on release.
- Sits between the ClockSync strobes, the transfer-engine state machine (req_active) and the nBG/is_bm pins and status bits.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for nBR_IN, nBGACK_IN and nAS_IN (minimum 2).
- BG_TIMEOUT, 4095, SYSCLK cycles in WAIT_BGACK before the grant is withdrawn.
- SETTLE_CLKS, 2, MC_CLK_FALLING strobes spent in RELEASE before ENGINE_HOLD drops.
- MIN_OWN_CLKS, 8, MC_CLK_FALLING strobes of guaranteed Pi ownership; used only with PI_MIN_OWN_EN.

Ports:
- SYSCLK  in  1  system clock (PLL output).
- RESET  in  1  synchronous, active-high reset.
- MC_CLK_FALLING  in  1  one-SYSCLK pulse per CLK_7M falling edge.
- nBR_IN  in  1  raw bus request from the Amiga bus, active low.
- nBGACK_IN  in  1  raw bus-grant acknowledge, active low.
- nAS_IN  in  1  raw address strobe as observed on the bus, active low.
- ENGINE_BUSY  in  1  transfer engine has a cycle in progress (req_active or state != WAIT).
- DENY_GRANT  in  1  Pi control bit; while 1, no new grant is started.
- ENGINE_HOLD  out  1  1 = transfer engine must not leave STATE_WAIT.
- BG_DRIVE  out  1  1 = drive nBG low (feeds nBG_OE).
- EXT_MASTER  out  1  1 = an external master owns the bus (status bit, replaces is_bm).
- GRANT_TIMEOUT  out  1  sticky; set when a grant is withdrawn on timeout; cleared by RESET or CLR_TIMEOUT.
- CLR_TIMEOUT  in  1  one-cycle pulse that clears GRANT_TIMEOUT.

Behaviour:
- Synchronisers: nBR_IN, nBGACK_IN and nAS_IN pass through SYNC_STAGES flops on SYSCLK. The internal br, bgack and as are active-high versions of the synchronised signals.
- Reset values: state IDLE; ENGINE_HOLD=0, BG_DRIVE=0, EXT_MASTER=0, GRANT_TIMEOUT=0; all counters 0. Reset mid-grant withdraws BG_DRIVE on the next edge.
- All outputs are registered.
- States:
  - IDLE: when br=1 and DENY_GRANT=0, set ENGINE_HOLD=1 and go to DRAIN.
  - DRAIN: wait for ENGINE_BUSY=0 and as=0, then go to GRANT. If br drops first, clear ENGINE_HOLD and go to IDLE.
  - GRANT: on the next MC_CLK_FALLING, set BG_DRIVE=1, clear the timeout counter and go to WAIT_BGACK.
  - WAIT_BGACK:
    - bgack=1 and as=0: BG_DRIVE=0, EXT_MASTER=1, go to OWNED.
    - br=0 and bgack=0 (request withdrawn): BG_DRIVE=0, go to RELEASE.
    - Counter reaches BG_TIMEOUT: BG_DRIVE=0, GRANT_TIMEOUT=1, go to RELEASE.
    - If the withdrawal and timeout conditions fire together, the withdrawal wins and GRANT_TIMEOUT is not set.
  - OWNED: when bgack=0, set EXT_MASTER=0 and go to RELEASE.
  - RELEASE: count SETTLE_CLKS MC_CLK_FALLING strobes. Then:
    - If br=1 and DENY_GRANT=0, go straight to GRANT with ENGINE_HOLD kept at 1 (chained masters).
    - Otherwise clear ENGINE_HOLD and go to IDLE.
- ENGINE_HOLD is 1 in every state except IDLE.
- The transfer engine is never interrupted: a grant only starts after ENGINE_BUSY=0.
- DENY_GRANT affects only IDLE and RELEASE. An active grant or ownership runs to completion.
- Latency: a br edge on the pin reaches IDLE→DRAIN after SYNC_STAGES+1 SYSCLK cycles. BG_DRIVE rises on the first MC_CLK_FALLING after DRAIN completes, plus 1 SYSCLK.
- Counter width is ceil(log2(BG_TIMEOUT+1)); the counter saturates and never wraps.
- CLR_TIMEOUT in the same cycle as a new timeout: set wins.

Optional Feature:
- Macro: PI_MIN_OWN_EN.
- Defined: on leaving RELEASE toward IDLE, a counter loads MIN_OWN_CLKS and decrements on each MC_CLK_FALLING. IDLE ignores br until the counter reaches 0, and the RELEASE→GRANT chaining is disabled, so the Pi always gets at least MIN_OWN_CLKS 7 MHz clocks between grants.
- Not defined: no counter exists and grants follow br immediately as described above.

Test Plan:
1. Idle engine, nBR low → ENGINE_HOLD=1 after 3 SYSCLK; BG_DRIVE=1 at the first subsequent MC_CLK_FALLING+1; nBGACK low with nAS high → BG_DRIVE=0, EXT_MASTER=1; nBGACK high → EXT_MASTER=0, ENGINE_HOLD=0 after 2 falling strobes.
2. nBR low while ENGINE_BUSY=1 for 40 cycles → BG_DRIVE stays 0 until 1 falling strobe after ENGINE_BUSY=0.
3. nBR low, then high before nBGACK → BG_DRIVE drops next cycle, GRANT_TIMEOUT=0, state returns to IDLE.
4. nBR held low, nBGACK never asserted, BG_TIMEOUT=100 → BG_DRIVE=0 and GRANT_TIMEOUT=1 at the 100th cycle; CLR_TIMEOUT pulse → 0.
5. DENY_GRANT=1 with nBR low for 500 cycles → ENGINE_HOLD=0 and BG_DRIVE=0 throughout; assert RESET while in OWNED → all outputs 0 next edge.
6. With PI_MIN_OWN_EN and MIN_OWN_CLKS=8, back-to-back requests → at least 8 falling strobes with ENGINE_HOLD=0 between grants.
